// File: rtl/io_port_gen.sv
// io_port_gen: parametrised memory-mapped I/O port (switches, LEDs, two buttons)
// on the pRead/pWrite bus. Buttons and switches are synchronised; buttons are
// also debounced and edge-detected. Read data is registered (1-cycle latency).
// Optional feature: define IO_IRQ_EN to add the registered irq output and the
// CTRL.irq_mask bit; without it CTRL bit1 reads 0 and its writes are ignored.

// Per-button conditioning: 2-FF synchroniser, debounce counter, rising-edge pulse.
module io_db #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);
  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync;
  logic          stable, stable_q;
  logic [CW-1:0] cnt;

  // Synchronise, then accept a new level only after DB_CYCLES differing cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync     <= '0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
    end else begin
      sync     <= {sync[0], raw};
      stable_q <= stable;
      if (sync[1] != stable) begin
        if (cnt == LAST) begin
          stable <= sync[1];
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  // Only 0->1 of the debounced level produces a one-cycle pulse.
  assign press = stable & ~stable_q;
endmodule

module io_port_gen #(
  parameter int SW_W      = 16,
  parameter int LED_W     = 12,
  parameter int DB_CYCLES = 16,
  parameter int ADDR_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pRead,
  input  logic              pWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       pWriteData,
  output logic [31:0]       pReadData,
  input  logic              buttonL,
  input  logic              buttonR,
  input  logic [SW_W-1:0]   switch,
  output logic [LED_W-1:0]  led
`ifdef IO_IRQ_EN
  ,
  output logic              irq
`endif
);
`ifdef IO_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_LED    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_SW     = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(3);

  logic [SW_W-1:0]  sw_s1, sw_s2, reg_sw;
  logic [LED_W-1:0] reg_led;
  logic             shown, in_valid, overflow, auto_mode, irq_mask;
  logic [1:0]       btn_raw, btn_press;
  logic             pL, pR;
  logic             rd_status, rd_sw, wr_led, wr_ctrl;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  assign unused_wdata = ^pWriteData;

  // Button lanes: index 0 = buttonL ("show LEDs"), 1 = buttonR ("sample switches").
  assign btn_raw = {buttonR, buttonL};
  for (genvar g = 0; g < 2; g++) begin : g_btn
    io_db #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_raw[g]),
      .press (btn_press[g])
    );
  end
  assign pL = btn_press[0];
  assign pR = btn_press[1];

  // Switches only need synchronising; they are sampled on a pR pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= switch;
      sw_s2 <= sw_s1;
    end
  end

  assign rd_status = pRead  && (addr == A_STATUS);
  assign rd_sw     = pRead  && (addr == A_SW);
  assign wr_led    = pWrite && (addr == A_LED);
  assign wr_ctrl   = pWrite && (addr == A_CTRL);

  // Read mux sees pre-update register contents.
  always_comb begin
    rd_mux = '0;
    case (addr)
      A_STATUS: rd_mux = {29'd0, overflow, in_valid, shown};
      A_SW:     rd_mux = 32'(reg_sw);
      A_CTRL:   rd_mux = {30'd0, irq_mask, auto_mode};
      default:  rd_mux = '0;
    endcase
  end

  // Register file: read capture, switch sampling, status flags, LED/CTRL writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      pReadData <= '0;
      reg_sw    <= '0;
      reg_led   <= '0;
      led       <= '0;
      shown     <= 1'b0;
      in_valid  <= 1'b0;
      overflow  <= 1'b0;
      auto_mode <= 1'b0;
      irq_mask  <= 1'b0;
    end else begin
      if (pRead) pReadData <= rd_mux;
      if (pR) reg_sw <= sw_s2;
      // A same-cycle pR keeps in_valid set and does not count as overflow.
      in_valid <= pR | (in_valid & ~rd_sw);
      overflow <= (pR & in_valid & ~rd_sw) | (overflow & ~rd_status);
      if (wr_led) begin
        reg_led <= pWriteData[LED_W-1:0];
        if (auto_mode) begin
          led   <= pWriteData[LED_W-1:0];
          shown <= 1'b1;
        end else begin
          shown <= 1'b0;
        end
      end
      // Manual show: old reg_led goes out; a colliding write still clears shown.
      if (pL && !auto_mode) begin
        led <= reg_led;
        if (!wr_led) shown <= 1'b1;
      end
      if (wr_ctrl) begin
        auto_mode <= pWriteData[0];
        irq_mask  <= pWriteData[1] & IRQ_EN;
      end
    end
  end

`ifdef IO_IRQ_EN
  // Registered interrupt: follows mask and flags with one cycle of lag.
  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= irq_mask & (in_valid | overflow);
  end
`endif
endmodule

// File: tb/tb_io_port_gen.sv
// Bench for io_port_gen (DB_CYCLES=4, SW_W=16, LED_W=12): constant vector table,
// hand-timed collision sequences and a random transaction-level model.
module tb_io_port_gen;
  localparam int SW_W = 16, LED_W = 12, DB = 4, ADDR_W = 3;
  // Raw edge -> 2 synchroniser stages -> DB differing cycles -> pulse visible.
  localparam int PULSE_LAT = 2 + DB;

  logic              clk = 1'b0, rst = 1'b1, pRead = 1'b0, pWrite = 1'b0;
  logic              buttonL = 1'b0, buttonR = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [31:0]       pWriteData = '0, pReadData;
  logic [SW_W-1:0]   switch = '0;
  logic [LED_W-1:0]  led;
`ifdef IO_IRQ_EN
  logic              irq;
  localparam bit HAS_IRQ = 1'b1;
`else
  localparam bit HAS_IRQ = 1'b0;
`endif

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  io_port_gen #(.SW_W(SW_W), .LED_W(LED_W), .DB_CYCLES(DB), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .pRead      (pRead),
    .pWrite     (pWrite),
    .addr       (addr),
    .pWriteData (pWriteData),
    .pReadData  (pReadData),
    .buttonL    (buttonL),
    .buttonR    (buttonR),
    .switch     (switch),
    .led        (led)
`ifdef IO_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  typedef struct {
    bit          wr;
    logic [2:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[$];

  // Transaction-level model state.
  logic [11:0] m_led, m_reg_led;
  logic [15:0] m_sw;
  bit          m_iv, m_ov, m_shown, m_auto, m_mask;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    pRead = 1'b1; addr = a;
    @(negedge clk);
    pRead = 1'b0;
    d = pReadData;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    pWrite = 1'b1; addr = a; pWriteData = d;
    @(negedge clk);
    pWrite = 1'b0;
  endtask

  task automatic set_btn(input bit r, input bit v);
    if (r) buttonR = v; else buttonL = v;
  endtask

  task automatic press(input bit r, input int len);
    set_btn(r, 1'b1);
    tick(len);
    set_btn(r, 1'b0);
    tick(DB + 8);
  endtask

  // Press a button and put one bus access exactly on the cycle the pulse acts.
  task automatic press_with(input bit r, input bit is_wr, input logic [2:0] a,
                            input logic [31:0] d, output logic [31:0] rdata);
    set_btn(r, 1'b1);
    tick(PULSE_LAT);
    addr = a; pWriteData = d;
    if (is_wr) pWrite = 1'b1; else pRead = 1'b1;
    @(negedge clk);
    pWrite = 1'b0; pRead = 1'b0;
    rdata = pReadData;
    tick(4);
    set_btn(r, 1'b0);
    tick(DB + 8);
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(name, d, exp);
  endtask

  task automatic model_reset();
    m_led = '0; m_reg_led = '0; m_sw = '0;
    m_iv = 0; m_ov = 0; m_shown = 0; m_auto = 0; m_mask = 0;
  endtask

  task automatic model_read(input logic [2:0] a, output logic [31:0] exp);
    case (a)
      3'd0: begin exp = {29'd0, m_ov, m_iv, m_shown}; m_ov = 0; end
      3'd2: begin exp = {16'd0, m_sw}; m_iv = 0; end
      3'd3: exp = {30'd0, m_mask, m_auto};
      default: exp = '0;
    endcase
  endtask

  initial begin
    logic [31:0] d, e;
    int op, len;
    logic [2:0] a;

    tick(3);
    rst = 1'b0;
    check("reset pReadData", pReadData, 32'h0);
    check("reset led", 32'(led), 32'h0);
`ifdef IO_IRQ_EN
    check("reset irq", 32'(irq), 32'h0);
`endif

    // Register map from reset: reads, ignored writes, CTRL masking.
    tbl.push_back('{0, 3'd0, 32'h0, 32'h0});
    tbl.push_back('{0, 3'd1, 32'h0, 32'h0});
    tbl.push_back('{0, 3'd2, 32'h0, 32'h0});
    tbl.push_back('{0, 3'd3, 32'h0, 32'h0});
    tbl.push_back('{0, 3'd5, 32'h0, 32'h0});
    tbl.push_back('{0, 3'd7, 32'h0, 32'h0});
    tbl.push_back('{1, 3'd3, 32'hFFFF_FFFC, 32'h0});
    tbl.push_back('{0, 3'd3, 32'h0, 32'h0});
    tbl.push_back('{1, 3'd0, 32'h0000_FFFF, 32'h0});
    tbl.push_back('{0, 3'd0, 32'h0, 32'h0});
    tbl.push_back('{1, 3'd2, 32'h0000_FFFF, 32'h0});
    tbl.push_back('{0, 3'd2, 32'h0, 32'h0});
    tbl.push_back('{1, 3'd5, 32'hFFFF_FFFF, 32'h0});
    tbl.push_back('{1, 3'd1, 32'h0000_FABC, 32'h0});
    tbl.push_back('{0, 3'd1, 32'h0, 32'h0});
    tbl.push_back('{0, 3'd0, 32'h0, 32'h0});
    tbl.push_back('{1, 3'd3, 32'h3, 32'h0});
    tbl.push_back('{0, 3'd3, 32'h0, HAS_IRQ ? 32'h3 : 32'h1});
    tbl.push_back('{1, 3'd3, 32'h0, 32'h0});
    tbl.push_back('{0, 3'd3, 32'h0, 32'h0});
    foreach (tbl[i]) begin
      if (tbl[i].wr) wr(tbl[i].a, tbl[i].d);
      else begin
        rd(tbl[i].a, d);
        check($sformatf("tbl[%0d] rd a=%0d", i, tbl[i].a), d, tbl[i].exp);
      end
      check($sformatf("tbl[%0d] led", i), 32'(led), 32'h0);
    end

    // Debounce: short glitch ignored, long press samples switches.
    press(1, DB - 1);
    rd_chk("glitch STATUS", 0, 32'h0);
    switch = 16'h1234; tick(3);
    press(1, 10);
    rd_chk("press STATUS", 0, 32'h2);
    rd_chk("press SW", 2, 32'h1234);
    rd_chk("press STATUS after SW", 0, 32'h0);

    // Overflow: sticky until a STATUS read.
    press(1, 10);
    press(1, 10);
    rd_chk("ovf STATUS", 0, 32'h6);
    rd_chk("ovf STATUS 2nd", 0, 32'h2);
    rd_chk("ovf SW", 2, 32'h1234);
    rd_chk("ovf STATUS cleared", 0, 32'h0);

    // Manual LED display.
    check("manual led before pL", 32'(led), 32'h0);
    press(0, 10);
    check("manual led after pL", 32'(led), 32'hABC);
    rd_chk("manual STATUS", 0, 32'h1);

    // pL colliding with an LED write: old reg_led shown, write clears shown.
    wr(1, 32'h123);
    check("led held after write", 32'(led), 32'hABC);
    press_with(0, 1, 3'd1, 32'h777, d);
    check("pL+wr led", 32'(led), 32'h123);
    rd_chk("pL+wr STATUS", 0, 32'h0);
    press(0, 10);
    check("pL after collision", 32'(led), 32'h777);

    // Auto mode: write goes straight to the LEDs, pL ignored.
    wr(3, 32'h1);
    check("auto on led unchanged", 32'(led), 32'h777);
    wr(1, 32'h055);
    check("auto write led", 32'(led), 32'h055);
    rd_chk("auto STATUS", 0, 32'h1);
    wr(1, 32'h0);
    press(0, 10);
    check("auto pL ignored", 32'(led), 32'h0);
    wr(3, 32'h0);

    // SW read colliding with pR: old reg_sw returned, in_valid stays set.
    switch = 16'h00FF; tick(3);
    press_with(1, 0, 3'd2, 32'h0, d);
    check("pR+SW rd data", d, 32'h1234);
    rd_chk("pR+SW STATUS", 0, 32'h3);
    rd_chk("pR+SW new SW", 2, 32'h00FF);
    rd_chk("pR+SW STATUS clr", 0, 32'h1);

    // STATUS read colliding with an overflow-setting pR: overflow survives.
    press(1, 10);
    press_with(1, 0, 3'd0, 32'h0, d);
    check("pR+STATUS rd data", d, 32'h3);
    rd_chk("pR+STATUS ovf kept", 0, 32'h7);
    rd_chk("pR+STATUS SW", 2, 32'h00FF);
    rd_chk("pR+STATUS final", 0, 32'h1);

`ifdef IO_IRQ_EN
    // irq lags in_valid by one cycle both ways.
    wr(3, 32'h2);
    buttonR = 1'b1;
    tick(PULSE_LAT + 1);
    check("irq not yet", 32'(irq), 32'h0);
    tick(1);
    check("irq raised", 32'(irq), 32'h1);
    tick(4); buttonR = 1'b0; tick(DB + 8);
    rd_chk("irq SW", 2, 32'h00FF);
    check("irq still high", 32'(irq), 32'h1);
    tick(1);
    check("irq cleared", 32'(irq), 32'h0);
`endif

    // Reset in the middle of a press discards it.
    buttonR = 1'b1; tick(3);
    rst = 1'b1; buttonR = 1'b0; tick(2);
    rst = 1'b0; tick(DB + 8);
    check("midrst led", 32'(led), 32'h0);
    rd_chk("midrst STATUS", 0, 32'h0);
    rd_chk("midrst SW", 2, 32'h0);
`ifdef IO_IRQ_EN
    check("midrst irq", 32'(irq), 32'h0);
`endif

    // Random transactions against the model.
    model_reset();
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 6);
      case (op)
        0: begin
          a = 3'($urandom_range(0, 7));
          rd(a, d);
          model_read(a, e);
          check($sformatf("rand[%0d] rd a=%0d", i, a), d, e);
        end
        1: begin
          d = $urandom;
          wr(1, d);
          m_reg_led = d[11:0];
          if (m_auto) begin m_led = d[11:0]; m_shown = 1; end
          else m_shown = 0;
        end
        2: begin
          d = 32'($urandom_range(0, 3));
          wr(3, d);
          m_auto = d[0];
          m_mask = d[1] & HAS_IRQ;
        end
        3: begin
          m_sw = 16'($urandom);
          switch = m_sw; tick(3);
          press(1, DB + 3 + $urandom_range(0, 4));
          if (m_iv) m_ov = 1;
          m_iv = 1;
        end
        4: begin
          press(0, DB + 3 + $urandom_range(0, 4));
          if (!m_auto) begin m_led = m_reg_led; m_shown = 1; end
        end
        5: begin
          len = $urandom_range(1, DB - 1);
          press(1'($urandom_range(0, 1)), len);
        end
        default: begin
          case ($urandom_range(0, 5))
            0: a = 3'd0;
            1: a = 3'd2;
            default: a = 3'($urandom_range(4, 7));
          endcase
          wr(a, $urandom);
        end
      endcase
      tick(1);
      check($sformatf("rand[%0d] led", i), 32'(led), 32'(m_led));
`ifdef IO_IRQ_EN
      check($sformatf("rand[%0d] irq", i), 32'(irq), 32'(m_mask & (m_iv | m_ov)));
`endif
    end
    model_read(0, e); rd(0, d); check("rand final STATUS", d, e);
    model_read(2, e); rd(2, d); check("rand final SW", d, e);
    model_read(3, e); rd(3, d); check("rand final CTRL", d, e);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
